// File: rtl/readback_checker.sv
// Read-back verdict stage for the SDRAM tester: samples one read word,
// compares it against the expected bytes and latches a verdict for the LEDs.
module readback_checker #(
   parameter int unsigned READ_LATENCY   = 3,
   parameter logic [20:0] CHECK_ADDR     = 21'h000000,
   parameter logic [7:0]  EXP_MAIN       = 8'hFE,
   parameter logic [7:0]  EXP_AUX        = 8'hE0,
   parameter int unsigned TIMEOUT_CYCLES = 14_000_000,
   parameter int unsigned BLINK_DIV      = 3_500_000
) (
   input  logic        clk14M,
   input  logic        reset14M_n,
   input  logic        mach_reading,
   input  logic        mach_error,
   input  logic [20:0] sdram_addr,
   input  logic [15:0] sdram_dout,
   output logic [15:0] captured_word,
   output logic        done,
   output logic [1:0]  fail_code,
   output logic        led_pass,
   output logic        led_fail,
   output logic        led_busy
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_LAT,
      COMPARE,
      PASS,
      FAIL,
      ERROR
   } state_t;

   localparam logic [1:0] CODE_OK   = 2'b00;
   localparam logic [1:0] CODE_DATA = 2'b01;
   localparam logic [1:0] CODE_SEQ  = 2'b10;
   localparam logic [1:0] CODE_TMO  = 2'b11;

   localparam logic [3:0]  LAT_LOAD   = 4'(READ_LATENCY - 1);
   localparam logic [23:0] WD_LAST    = 24'(TIMEOUT_CYCLES - 1);
   localparam logic [23:0] BLINK_LAST = 24'(BLINK_DIV - 1);

   state_t      state;
   state_t      state_nx;
   logic [3:0]  lat_cnt;
   logic [3:0]  lat_cnt_nx;
   logic [23:0] wd_cnt;
   logic [23:0] wd_cnt_nx;
   logic [23:0] blink_cnt;
   logic [23:0] blink_cnt_nx;
   logic [15:0] captured_nx;
   logic        done_nx;
   logic [1:0]  fail_code_nx;
   logic        led_pass_nx;
   logic        led_fail_nx;
   logic        led_busy_nx;

   logic start;
   logic match;

   assign start = mach_reading && (sdram_addr == CHECK_ADDR);
   assign match = (captured_word[7:0] == EXP_MAIN)
               && (captured_word[15:8] == EXP_AUX);

   always_comb begin
      state_nx     = state;
      lat_cnt_nx   = lat_cnt;
      wd_cnt_nx    = wd_cnt;
      blink_cnt_nx = blink_cnt;
      captured_nx  = captured_word;
      done_nx      = done;
      fail_code_nx = fail_code;
      led_pass_nx  = led_pass;
      led_fail_nx  = led_fail;
      led_busy_nx  = led_busy;

      unique case (state)
         IDLE: begin
            if (mach_error) begin
               state_nx     = ERROR;
               fail_code_nx = CODE_SEQ;
            end else if (start) begin
               state_nx   = WAIT_LAT;
               lat_cnt_nx = LAT_LOAD;
            end else if (wd_cnt == WD_LAST) begin
               state_nx     = ERROR;
               fail_code_nx = CODE_TMO;
            end else begin
               wd_cnt_nx = wd_cnt + 24'd1;
            end
         end
         WAIT_LAT: begin
            // address/read strobe are don't-care once the window is armed
            if (mach_error) begin
               state_nx     = ERROR;
               fail_code_nx = CODE_SEQ;
            end else if (lat_cnt == 4'd0) begin
               state_nx    = COMPARE;
               captured_nx = sdram_dout;
            end else begin
               lat_cnt_nx = lat_cnt - 4'd1;
            end
         end
         COMPARE: begin
            if (mach_error) begin
               state_nx     = ERROR;
               fail_code_nx = CODE_SEQ;
            end else if (match) begin
               state_nx     = PASS;
               fail_code_nx = CODE_OK;
            end else begin
               state_nx     = FAIL;
               fail_code_nx = CODE_DATA;
            end
         end
         FAIL: begin
            if (blink_cnt == BLINK_LAST) begin
               blink_cnt_nx = 24'd0;
               led_fail_nx  = ~led_fail;
            end else begin
               blink_cnt_nx = blink_cnt + 24'd1;
            end
         end
         PASS, ERROR: begin
         end
         default: begin
            state_nx = IDLE;
         end
      endcase

      // LED/done image for any transition out of the busy states
      if (state != state_nx) begin
         unique case (state_nx)
            PASS: begin
               done_nx     = 1'b1;
               led_pass_nx = 1'b1;
               led_fail_nx = 1'b0;
               led_busy_nx = 1'b0;
            end
            FAIL: begin
               done_nx      = 1'b1;
               led_pass_nx  = 1'b0;
               led_fail_nx  = 1'b1;
               led_busy_nx  = 1'b0;
               blink_cnt_nx = 24'd0;
            end
            ERROR: begin
               done_nx     = 1'b1;
               led_pass_nx = 1'b0;
               led_fail_nx = 1'b1;
               led_busy_nx = 1'b0;
            end
            default: begin
               led_busy_nx = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk14M) begin
      if (!reset14M_n) begin
         state         <= IDLE;
         lat_cnt       <= 4'd0;
         wd_cnt        <= 24'd0;
         blink_cnt     <= 24'd0;
         captured_word <= 16'h0000;
         done          <= 1'b0;
         fail_code     <= CODE_OK;
         led_pass      <= 1'b0;
         led_fail      <= 1'b0;
         led_busy      <= 1'b1;
      end else begin
         state         <= state_nx;
         lat_cnt       <= lat_cnt_nx;
         wd_cnt        <= wd_cnt_nx;
         blink_cnt     <= blink_cnt_nx;
         captured_word <= captured_nx;
         done          <= done_nx;
         fail_code     <= fail_code_nx;
         led_pass      <= led_pass_nx;
         led_fail      <= led_fail_nx;
         led_busy      <= led_busy_nx;
      end
   end

endmodule

// File: tb/tb_readback_checker.sv
// Scoreboard bench for readback_checker: verdicts queued at start,
// popped and compared once the verdict edge is reached.
module tb_readback_checker;

   logic        clk14M;
   logic        reset14M_n;
   logic        mach_reading;
   logic        mach_error;
   logic [20:0] sdram_addr;
   logic [15:0] sdram_dout;
   logic [15:0] captured_word;
   logic        done;
   logic [1:0]  fail_code;
   logic        led_pass;
   logic        led_fail;
   logic        led_busy;

   typedef struct {
      logic [15:0] word;
      logic [1:0]  code;
   } exp_t;

   exp_t sb[$];
   int   vectors;
   int   miscompares;

   readback_checker #(
      .READ_LATENCY  (3),
      .CHECK_ADDR    (21'h000000),
      .EXP_MAIN      (8'hFE),
      .EXP_AUX       (8'hE0),
      .TIMEOUT_CYCLES(100),
      .BLINK_DIV     (4)
   ) dut (
      .clk14M       (clk14M),
      .reset14M_n   (reset14M_n),
      .mach_reading (mach_reading),
      .mach_error   (mach_error),
      .sdram_addr   (sdram_addr),
      .sdram_dout   (sdram_dout),
      .captured_word(captured_word),
      .done         (done),
      .fail_code    (fail_code),
      .led_pass     (led_pass),
      .led_fail     (led_fail),
      .led_busy     (led_busy)
   );

   initial clk14M = 1'b0;
   always #5 clk14M = ~clk14M;

   task automatic tick();
      @(posedge clk14M);
      #1;
   endtask

   task automatic do_reset();
      reset14M_n   = 1'b0;
      mach_reading = 1'b0;
      mach_error   = 1'b0;
      sdram_addr   = 21'h000000;
      sdram_dout   = 16'h0000;
      tick();
      reset14M_n = 1'b1;
   endtask

   // start at E0, present word only at E0+3, return just after E0+3
   task automatic drive_start(input logic [15:0] word);
      mach_reading = 1'b1;
      sdram_addr   = 21'h000000;
      sdram_dout   = ~word;
      tick();
      mach_reading = 1'b0;
      sdram_addr   = 21'h0ABCDE;
      tick();
      mach_reading = 1'b1;
      sdram_addr   = 21'h000000;
      tick();
      mach_reading = 1'b0;
      sdram_dout   = word;
      tick();
      sdram_dout = ~word;
   endtask

   task automatic pop_verdict(input string name);
      exp_t e;
      vectors++;
      if (sb.size() == 0) begin
         miscompares++;
         $display("FAIL %s_sb: scoreboard empty", name);
      end else begin
         e = sb.pop_front();
         if (captured_word !== e.word || fail_code !== e.code) begin
            miscompares++;
            $display("FAIL %s: word %h code %b, want %h %b",
                     name, captured_word, fail_code, e.word, e.code);
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      mach_error = 1'b1;
      tick();
      mach_error = 1'b0;
      reset14M_n = 1'b0;
      tick();
      vectors++;
      if (captured_word !== 16'h0000 || done !== 1'b0 ||
          fail_code !== 2'b00 || led_pass !== 1'b0 ||
          led_fail !== 1'b0 || led_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL reset: w=%h d=%b c=%b p=%b f=%b b=%b want 0000 0 00 0 0 1",
                  captured_word, done, fail_code, led_pass, led_fail, led_busy);
      end
      reset14M_n = 1'b1;
   endtask

   task automatic test_pass();
      exp_t e;
      do_reset();
      e.word = 16'hE0FE;
      e.code = 2'b00;
      sb.push_back(e);
      drive_start(16'hE0FE);
      vectors++;
      if (done !== 1'b0 || led_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL pass_early: done=%b busy=%b want 0 1", done, led_busy);
      end
      tick();
      vectors++;
      if (done !== 1'b1 || led_pass !== 1'b1 || led_busy !== 1'b0 ||
          led_fail !== 1'b0) begin
         miscompares++;
         $display("FAIL pass_leds: d=%b p=%b b=%b f=%b want 1 1 0 0",
                  done, led_pass, led_busy, led_fail);
      end
      pop_verdict("pass_verdict");
   endtask

   task automatic test_mismatch();
      logic [15:0] words[2];
      exp_t        e;
      logic        want;
      words[0] = 16'hE0FF;
      words[1] = 16'h00FE;
      for (int w = 0; w < 2; w++) begin
         do_reset();
         e.word = words[w];
         e.code = (words[w] == 16'hE0FE) ? 2'b00 : 2'b01;
         sb.push_back(e);
         drive_start(words[w]);
         tick();
         vectors++;
         if (done !== 1'b1 || led_pass !== 1'b0 || led_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mis_flags: d=%b p=%b b=%b want 1 0 0",
                     done, led_pass, led_busy);
         end
         pop_verdict("mismatch_verdict");
         if (w == 0) begin
            for (int i = 0; i < 9; i++) begin
               want = ((i / 4) % 2) == 0;
               vectors++;
               if (led_fail !== want) begin
                  miscompares++;
                  $display("FAIL blink[%0d]: got %b want %b", i, led_fail, want);
               end
               if (i < 8) tick();
            end
         end
      end
   endtask

   task automatic test_seq_error();
      exp_t e;
      do_reset();
      e.word = 16'h0000;
      e.code = 2'b10;
      sb.push_back(e);
      mach_reading = 1'b1;
      mach_error   = 1'b1;
      sdram_dout   = 16'hE0FE;
      tick();
      mach_error = 1'b0;
      pop_verdict("seqerr_verdict");
      for (int i = 0; i < 8; i++) begin
         tick();
         vectors++;
         if (done !== 1'b1 || fail_code !== 2'b10 || led_fail !== 1'b1 ||
             led_pass !== 1'b0 || led_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL seqerr_hold[%0d]: d=%b c=%b f=%b p=%b b=%b",
                     i, done, fail_code, led_fail, led_pass, led_busy);
         end
      end
      mach_reading = 1'b0;
   endtask

   task automatic test_error_in_wait();
      exp_t e;
      do_reset();
      e.word = 16'h0000;
      e.code = 2'b10;
      sb.push_back(e);
      mach_reading = 1'b1;
      tick();
      mach_reading = 1'b0;
      sdram_dout   = 16'hE0FE;
      tick();
      mach_error = 1'b1;
      tick();
      mach_error = 1'b0;
      vectors++;
      if (done !== 1'b1 || led_fail !== 1'b1) begin
         miscompares++;
         $display("FAIL waiterr: done=%b fail=%b want 1 1", done, led_fail);
      end
      pop_verdict("waiterr_verdict");
   endtask

   task automatic test_timeout();
      exp_t e;
      do_reset();
      e.word = 16'h0000;
      e.code = 2'b11;
      sb.push_back(e);
      for (int i = 0; i < 99; i++) tick();
      vectors++;
      if (done !== 1'b0 || fail_code !== 2'b00 || led_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL tmo_early: d=%b c=%b b=%b want 0 00 1",
                  done, fail_code, led_busy);
      end
      tick();
      vectors++;
      if (done !== 1'b1 || led_fail !== 1'b1) begin
         miscompares++;
         $display("FAIL tmo_flags: d=%b f=%b want 1 1", done, led_fail);
      end
      pop_verdict("tmo_verdict");
   endtask

   task automatic test_addr_filter();
      exp_t e;
      int   bad;
      do_reset();
      e.word = 16'h0000;
      e.code = 2'b11;
      sb.push_back(e);
      mach_reading = 1'b1;
      sdram_addr   = 21'h000001;
      sdram_dout   = 16'hE0FE;
      bad = 0;
      for (int i = 0; i < 99; i++) begin
         tick();
         if (led_busy !== 1'b1 || done !== 1'b0) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL filter_busy: %0d cycles left busy, want 0", bad);
      end
      tick();
      pop_verdict("filter_verdict");
      mach_reading = 1'b0;
   endtask

   task automatic test_reset_mid();
      exp_t e;
      do_reset();
      mach_reading = 1'b1;
      sdram_dout   = 16'h1234;
      tick();
      mach_reading = 1'b0;
      tick();
      reset14M_n = 1'b0;
      tick();
      reset14M_n = 1'b1;
      vectors++;
      if (captured_word !== 16'h0000 || done !== 1'b0 ||
          fail_code !== 2'b00 || led_pass !== 1'b0 ||
          led_fail !== 1'b0 || led_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL midreset: w=%h d=%b c=%b p=%b f=%b b=%b",
                  captured_word, done, fail_code, led_pass, led_fail, led_busy);
      end
      for (int i = 0; i < 4; i++) tick();
      vectors++;
      if (done !== 1'b0 || captured_word !== 16'h0000) begin
         miscompares++;
         $display("FAIL midreset_quiet: d=%b w=%h want 0 0000",
                  done, captured_word);
      end
      e.word = 16'hE0FE;
      e.code = 2'b00;
      sb.push_back(e);
      drive_start(16'hE0FE);
      vectors++;
      if (done !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_early: done=%b want 0", done);
      end
      tick();
      vectors++;
      if (led_pass !== 1'b1 || done !== 1'b1) begin
         miscompares++;
         $display("FAIL midreset_pass: p=%b d=%b want 1 1", led_pass, done);
      end
      pop_verdict("midreset_verdict");
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      do_reset();
      test_reset();
      test_pass();
      test_mismatch();
      test_seq_error();
      test_error_in_wait();
      test_timeout();
      test_addr_filter();
      test_reset_mid();
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL sb_drain: %0d left, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
